// File: rtl/hack_boot_pkg.sv
// Shared types and helpers for the Hack boot sequencer and its models.
package hack_boot_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LOAD,
        CSUM,
        HOLD,
        RUN,
        ERR
    } state_t;

    // Running program checksum: plain 16-bit wrapping add.
    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                   input logic [WORD_W-1:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/hack_boot_sequencer_if.sv
// Valid/ready word stream feeding the boot sequencer.
interface hack_boot_sequencer_if;
    import hack_boot_pkg::*;

    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/hack_boot_sequencer.sv
// Boot controller: streams a length-prefixed, checksummed image into
// instruction memory and releases CPU reset once the image verifies.
module hack_boot_sequencer
    import hack_boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned MAX_WORDS   = 32768,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    hack_boot_sequencer_if.slave  stream,
    output logic                  rom_we,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [WORD_W-1:0]     rom_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   len_q;
    logic [WORD_W-1:0]   cnt_q;
    logic [WORD_W-1:0]   sum_q;
    logic [HOLD_W-1:0]   hold_q;

    logic xfer_c;
    logic len_bad_c;
    logic last_word_c;
    logic hold_end_c;

    assign xfer_c      = stream.s_valid & stream.s_ready;
    assign len_bad_c   = (stream.s_data == '0) || (32'(stream.s_data) > MAX_WORDS);
    assign last_word_c = (cnt_q == (len_q - WORD_W'(1)));
    assign hold_end_c  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LEN;
            LEN: begin
                if (xfer_c) state_next = len_bad_c ? ERR : LOAD;
            end
            LOAD: begin
                if (xfer_c && last_word_c) state_next = CSUM;
            end
            CSUM: begin
                if (xfer_c) state_next = (stream.s_data == sum_q) ? HOLD : ERR;
            end
            HOLD: if (hold_end_c) state_next = RUN;
            RUN:  if (start) state_next = LEN;
            ERR:  if (start) state_next = LEN;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags decode the upcoming state
    always_ff @(posedge CLK) begin
        if (!reset) begin
            len_q          <= '0;
            cnt_q          <= '0;
            sum_q          <= '0;
            hold_q         <= '0;
            rom_we         <= 1'b0;
            rom_addr       <= '0;
            rom_wdata      <= '0;
            stream.s_ready <= 1'b0;
            cpu_reset      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                LEN: begin
                    if (xfer_c && !len_bad_c) begin
                        len_q <= stream.s_data;
                        cnt_q <= '0;
                        sum_q <= '0;
                    end
                end
                LOAD: begin
                    if (xfer_c) begin
                        rom_we    <= 1'b1;
                        rom_addr  <= ADDR_W'(cnt_q);
                        rom_wdata <= stream.s_data;
                        cnt_q     <= cnt_q + WORD_W'(1);
                        sum_q     <= csum_add(sum_q, stream.s_data);
                    end
                end
                default: ;
            endcase

            hold_q <= (state == HOLD && !hold_end_c) ? hold_q + HOLD_W'(1) : '0;

            stream.s_ready <= (state_next == LEN) || (state_next == LOAD) || (state_next == CSUM);
            busy           <= (state_next == LEN) || (state_next == LOAD) ||
                              (state_next == CSUM) || (state_next == HOLD);
            done           <= (state_next == RUN);
            error          <= (state_next == ERR);
            cpu_reset      <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Self-checking bench for hack_boot_sequencer: vector table, corner sequences
// and randomized images checked against a simple image/checksum model.
module tb_hack_boot_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    hack_boot_sequencer_if bus();

    hack_boot_sequencer #(
        .ADDR_W     (15),
        .MAX_WORDS  (32768),
        .HOLD_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .stream   (bus.slave),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;

    always @(posedge CLK) begin
        if (rom_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    // Called on a negedge; returns on the negedge after the word was accepted.
    task automatic send(input logic [15:0] d);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 64) begin
            check("ready_timeout", 32'(bus.s_ready), 32'd1);
            bus.s_valid = 1'b0;
            return;
        end
        @(negedge CLK);
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Reference checksum: sum of program words modulo 2^16.
    function automatic logic [15:0] model_sum(input logic [15:0] w[$]);
        int unsigned s = 0;
        foreach (w[i]) s = (s + 32'(w[i])) % 65536;
        return 16'(s);
    endfunction

    task automatic load(input string tag, input logic [15:0] len, input logic [15:0] words[$],
                        input logic [15:0] csum, input int gap_after, input int gap_len,
                        input bit exp_ok);
        int base;
        pulse_start();
        check({tag, ".start_busy"},   32'(busy),          32'd1);
        check({tag, ".start_cpurst"}, 32'(cpu_reset),     32'd1);
        check({tag, ".start_done"},   32'(done),          32'd0);
        check({tag, ".start_error"},  32'(error),         32'd0);
        check({tag, ".start_ready"},  32'(bus.s_ready),   32'd1);
        base = we_cnt;
        send(len);
        if (len == 16'd0 || 32'(len) > 32768) begin
            check({tag, ".len_error"}, 32'(error),       32'd1);
            check({tag, ".len_ready"}, 32'(bus.s_ready), 32'd0);
            check({tag, ".len_cpurst"}, 32'(cpu_reset),  32'd1);
            tick(3);
            check({tag, ".len_no_we"}, 32'(we_cnt - base), 32'd0);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            send(words[i]);
            check({tag, ".we"},    32'(rom_we),    32'd1);
            check({tag, ".addr"},  32'(rom_addr),  32'(i));
            check({tag, ".wdata"}, 32'(rom_wdata), 32'(words[i]));
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    start = (g == 2);
                    @(negedge CLK);
                    check({tag, ".gap_we"}, 32'(rom_we), 32'd0);
                end
                start = 1'b0;
            end
        end
        send(csum);
        if (exp_ok) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, ".hold_cpurst"}, 32'(cpu_reset), 32'd1);
                check({tag, ".hold_done"},   32'(done),      32'd0);
                tick();
            end
            check({tag, ".run_cpurst"}, 32'(cpu_reset), 32'd0);
            check({tag, ".run_done"},   32'(done),      32'd1);
            check({tag, ".run_busy"},   32'(busy),      32'd0);
            check({tag, ".run_error"},  32'(error),     32'd0);
        end else begin
            check({tag, ".err_error"},  32'(error),     32'd1);
            check({tag, ".err_done"},   32'(done),      32'd0);
            check({tag, ".err_cpurst"}, 32'(cpu_reset), 32'd1);
            tick(3);
            check({tag, ".err_sticky"}, 32'(error),     32'd1);
            check({tag, ".err_cpurst2"}, 32'(cpu_reset), 32'd1);
        end
        check({tag, ".we_count"}, 32'(we_cnt - base), 32'(len));
    endtask

    typedef struct {
        string           tag;
        logic [15:0]     len;
        logic [3:0][15:0] w;
        logic [15:0]     csum;
        int              gap_after;
        int              gap_len;
        bit              exp_ok;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] q[$];
    logic [15:0] big[$];

    initial begin
        vecs[0] = '{"good",     16'd3, {16'h0, 16'h0001, 16'hEC10, 16'h0010}, 16'hEC21, -1, 0, 1'b1};
        vecs[1] = '{"badsum",   16'd3, {16'h0, 16'h0001, 16'hEC10, 16'h0010}, 16'hEC22, -1, 0, 1'b0};
        vecs[2] = '{"recover",  16'd3, {16'h0, 16'h0001, 16'hEC10, 16'h0010}, 16'hEC21, -1, 0, 1'b1};
        vecs[3] = '{"len0",     16'd0, {16'h0, 16'h0, 16'h0, 16'h0},          16'h0000, -1, 0, 1'b0};
        vecs[4] = '{"len32769", 16'd32769, {16'h0, 16'h0, 16'h0, 16'h0},      16'h0000, -1, 0, 1'b0};
        vecs[5] = '{"bp",       16'd3, {16'h0, 16'h0001, 16'hEC10, 16'h0010}, 16'hEC21, 0, 5, 1'b1};
        vecs[6] = '{"one",      16'd1, {16'h0, 16'h0, 16'h0, 16'hFFFF},       16'hFFFF, -1, 0, 1'b1};
        vecs[7] = '{"wrap",     16'd2, {16'h0, 16'h0, 16'h0002, 16'hFFFF},    16'h0001, -1, 0, 1'b1};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        start       = 1'b1;
        reset       = 1'b0;
        tick(2);
        start = 1'b0;
        check("rst_cpurst", 32'(cpu_reset),   32'd1);
        check("rst_ready",  32'(bus.s_ready), 32'd0);
        check("rst_we",     32'(rom_we),      32'd0);
        check("rst_addr",   32'(rom_addr),    32'd0);
        check("rst_wdata",  32'(rom_wdata),   32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_error",  32'(error),       32'd0);
        reset = 1'b1;
        tick(2);
        check("idle_busy",  32'(busy),        32'd0);
        check("idle_ready", 32'(bus.s_ready), 32'd0);

        foreach (vecs[v]) begin
            q.delete();
            if (vecs[v].len >= 16'd1 && vecs[v].len <= 16'd4)
                for (int i = 0; i < int'(vecs[v].len); i++) q.push_back(vecs[v].w[i]);
            load(vecs[v].tag, vecs[v].len, q, vecs[v].csum,
                 vecs[v].gap_after, vecs[v].gap_len, vecs[v].exp_ok);
        end

        // Reset after two of three program words
        begin
            int base;
            pulse_start();
            send(16'd3);
            send(16'h1111);
            send(16'h2222);
            reset = 1'b0;
            tick();
            check("midrst_cpurst", 32'(cpu_reset),   32'd1);
            check("midrst_ready",  32'(bus.s_ready), 32'd0);
            check("midrst_we",     32'(rom_we),      32'd0);
            check("midrst_busy",   32'(busy),        32'd0);
            check("midrst_done",   32'(done),        32'd0);
            reset = 1'b1;
            base = we_cnt;
            tick(3);
            check("midrst_no_we",  32'(we_cnt - base), 32'd0);
            check("midrst_idle",   32'(busy),          32'd0);
            q.delete();
            q.push_back(16'h0010); q.push_back(16'hEC10); q.push_back(16'h0001);
            load("after_rst", 16'd3, q, 16'hEC21, -1, 0, 1'b1);
        end

        for (int r = 0; r < 10; r++) begin
            int unsigned n;
            logic [15:0] cs;
            bit want_ok;
            n = $urandom_range(1, 12);
            q.delete();
            for (int i = 0; i < int'(n); i++) q.push_back(16'($urandom));
            want_ok = ($urandom_range(0, 3) != 0);
            cs = model_sum(q);
            if (!want_ok) cs = cs + 16'($urandom_range(1, 65535));
            load($sformatf("rand%0d", r), 16'(n), q, cs,
                 int'($urandom_range(0, n - 1)), int'($urandom_range(0, 3)),
                 cs == model_sum(q));
        end

        big.delete();
        for (int i = 0; i < 32768; i++) big.push_back(16'($urandom));
        load("max", 16'h8000, big, model_sum(big), -1, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
